// File: rtl/instr_fetch_if.sv
// Fetch-to-decode bundle: the fetch stage drives it through the "in" modport,
// and decode reads it through "out".
interface data_fetch_io;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;

    modport in  (output pc, output instr, output pc_plus4);
    modport out (input  pc, input  instr, input  pc_plus4);
endinterface

// File: rtl/instr_fetch.sv
// IF stage: owns the fetch PC, drives the synchronous instruction BRAM and
// holds the IF/ID register, applying stall, flush, redirect and halt.

module instr_fetch_chk (
    input logic clk,
    input logic rst,
    input logic stall_f,
    input logic stall_d
);
    // The hazard unit must never hold decode while letting fetch run.
    a_no_stall_d_without_stall_f: assert property (
        @(posedge clk) disable iff (!rst) !(stall_d && !stall_f)
    ) else $error("stall_d asserted without stall_f");
endmodule

module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_f,
    input  logic         stall_d,
    input  logic         flush_d,
    input  logic         pc_src_e,
    input  logic [31:0]  pc_target_e,
    input  logic         halt_e,
    output logic [31:0]  imem_addr,
    output logic         imem_en,
    input  logic [31:0]  imem_rdata,
    data_fetch_io.in     data_fetch_if,
    output logic         halted,
    output logic [31:0]  fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_run;
    logic        w_halted;

    logic [31:0] r_pc_f;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_f_plus4;

    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic [31:0] r_fetch_count;

    logic        w_kill_slot;
    logic        w_load_slot;

    assign w_pc_f_plus4 = r_pc_f + 32'd4;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: halt is ignored while decode is held for a hazard.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (halt_e && !stall_d) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_run    = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_run    = 1'b1;
                w_halted = 1'b0;
            end
            ST_HALTED: begin
                w_run    = 1'b0;
                w_halted = 1'b1;
            end
            default: begin
                w_run    = 1'b0;
                w_halted = 1'b0;
            end
        endcase
    end

    // Next fetch PC: halt beats redirect, redirect beats stall.
    always_comb begin
        w_pc_next = r_pc_f;
        if (halt_e || !w_run) begin
            w_pc_next = r_pc_f;
        end else if (pc_src_e) begin
            w_pc_next = pc_target_e;
        end else if (stall_f) begin
            w_pc_next = r_pc_f;
        end else begin
            w_pc_next = w_pc_f_plus4;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_f <= RESET_PC;
        end else begin
            r_pc_f <= w_pc_next;
        end
    end

    // IF/ID slot decision: flush/redirect beat stall_d, which beats halt and bubbles.
    always_comb begin
        w_kill_slot = 1'b0;
        w_load_slot = 1'b0;
        if (flush_d || pc_src_e) begin
            w_kill_slot = 1'b1;
        end else if (stall_d) begin
            w_kill_slot = 1'b0;
        end else if (!w_run || halt_e || stall_f) begin
            w_kill_slot = 1'b1;
        end else begin
            w_load_slot = 1'b1;
        end
    end

    // IF/ID register; the BRAM read on this same edge lines up with r_pc_d.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_d       <= 32'h0000_0000;
            r_pc_plus4_d <= 32'h0000_0000;
            r_valid_d    <= 1'b0;
        end else if (w_load_slot) begin
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_f_plus4;
            r_valid_d    <= 1'b1;
        end else if (w_kill_slot) begin
            r_valid_d    <= 1'b0;
        end else begin
            r_valid_d    <= r_valid_d;
        end
    end

    // Count of valid instructions handed to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_load_slot) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign imem_addr           = r_pc_f;
    assign imem_en             = !stall_d && w_run;
    assign halted              = w_halted;
    assign fetch_count         = r_fetch_count;
    assign data_fetch_if.pc       = r_pc_d;
    assign data_fetch_if.pc_plus4 = r_pc_plus4_d;
    assign data_fetch_if.instr    = r_valid_d ? imem_rdata : NOP_INSTR;

    instr_fetch_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .stall_f (stall_f),
        .stall_d (stall_d)
    );

endmodule
